seq_stim_gen: RTL
=================

SEQ_STIM_GEN -- requirements
Module: seq_stim_gen

Interface
REQ-001 Parameter: PAT_W, 16, width of the pattern word (max serial length).
REQ-002 Parameter: LEN_W, 5, width of pat_len; SHALL satisfy 2**LEN_W > PAT_W.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: pat_valid  input  1  pattern load request.
REQ-006 Port: pat_ready  output  1  block can accept a pattern; high exactly in IDLE.
REQ-007 Port: pat_data  input  PAT_W  serial pattern, transmitted LSB first.
REQ-008 Port: pat_len  input  LEN_W  number of bits to send; valid range 0..PAT_W.
REQ-009 Port: C  output  1  serial stimulus bit, registered.
REQ-010 Port: c_valid  output  1  C carries a pattern bit this cycle, registered.
REQ-011 Port: busy  output  1  high in SHIFT and DONE.
REQ-012 Port: done  output  1  one-cycle pulse after the last bit.
REQ-013 Port: Y  input  1  response of the downstream sequence circuit; used only with SEQ_STIM_CHECK_EN.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE->SHIFT SHALL occur on a clk edge with pat_valid&&pat_ready and pat_len>0. pat_data and pat_len SHALL be captured on that edge.
REQ-016 An accept with pat_len==0 SHALL go IDLE->DONE directly; no bit is sent.
REQ-017 An accept with pat_len>PAT_W SHALL be clamped to PAT_W.
REQ-018 In SHIFT, C SHALL equal bit k of the captured pattern and c_valid SHALL be 1 in the k-th cycle after accept, for k=0..len-1; first bit in the cycle after accept.
REQ-019 After the bit len-1 cycle, the FSM SHALL go SHIFT->DONE; done=1 for exactly one cycle, then DONE->IDLE.
REQ-020 Outside SHIFT, C SHALL be 0 and c_valid SHALL be 0.
REQ-021 pat_valid in SHIFT or DONE SHALL be ignored (pat_ready=0); no queuing.
REQ-022 Throughput: a new accept is possible in the cycle after done; minimum accept-to-accept interval is len+2 cycles.

Reset
REQ-023 With rst_n low at a clk edge: state=IDLE, C=0, c_valid=0, done=0, busy=0, and the internal counter and shift register are cleared.
REQ-024 Reset mid-SHIFT SHALL abort the pattern with no done pulse; pat_ready=1 in the first cycle after rst_n rises.

Configuration
REQ-025 Macro SEQ_STIM_CHECK_EN, when defined, SHALL compile in a reference checker plus output ports err (1) and mismatch_cnt (8).
REQ-026 Checker model states S0..S3, updated every clk from C:
- S0: C=0->S0, C=1->S1
- S1: C=0->S3, C=1->S1
- S2: C=0->S0, C=1->S2
- S3: C=0->S3, C=1->S2
REQ-027 Expected Y SHALL be 1 in S3, 1 in S2 when C=1, and 0 otherwise; it is computed combinationally from model state and current C.
REQ-028 When c_valid=1 and Y != expected Y, err SHALL set (sticky) and mismatch_cnt SHALL increment, saturating at 255.
REQ-029 Model state SHALL reset to S0, err to 0 and mismatch_cnt to 0 on reset. err and mismatch_cnt SHALL also clear on each accept; the model state SHALL NOT clear on accept.
REQ-030 Without SEQ_STIM_CHECK_EN: no err/mismatch_cnt ports, Y is unused, and all other behaviour is identical.

Verification
REQ-031 Accept pat_data=0x0006, pat_len=4 at cycle 0 -> C=0,1,1,0 with c_valid=1 in cycles 1-4; done=1 in cycle 5; pat_ready=1 in cycle 6.
REQ-032 Accept with pat_len=0 -> c_valid never high; done=1 in the cycle after accept.
REQ-033 Accept with pat_len=20 (PAT_W=16) -> exactly 16 bits sent; done in cycle 17.
REQ-034 Assert rst_n low in cycle 2 of a 16-bit send -> C=0, c_valid=0 next cycle; no done pulse; pat_ready=1 after release.
REQ-035 pat_valid held high through a whole send -> a second accept occurs only in the cycle after done.
REQ-036 (SEQ_STIM_CHECK_EN) Send 0x0006, len 4, from reset with Y driven from a correct model -> err=0. Force Y=1 on bit 0 -> err=1, mismatch_cnt=1.

Source files
------------

// File: rtl/seq_stim_gen.sv
// Serial stimulus generator: shifts a captured pattern out LSB first on C, pulses done after.
// Optional response checker on Y compiled in with SEQ_STIM_CHECK_EN (adds err and mismatch_cnt).
module seq_stim_gen #(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  output logic             C,
  output logic             c_valid,
  output logic             busy,
  output logic             done,
  input  logic             Y
`ifdef SEQ_STIM_CHECK_EN
  ,
  output logic             err,
  output logic [7:0]       mismatch_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cv_q, cv_d;

  logic             accept;
  logic [LEN_W-1:0] len_eff;

  assign accept  = pat_valid && (state_q == StIdle);
  assign len_eff = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;

  // cnt_q holds the number of bits still to send after the one currently on C.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    c_d     = 1'b0;
    cv_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (len_eff == '0) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
            c_d     = pat_data[0];
            cv_d    = 1'b1;
            sr_d    = pat_data >> 1;
            cnt_d   = len_eff - LEN_W'(1);
          end
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          c_d   = sr_q[0];
          cv_d  = 1'b1;
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cv_q    <= cv_d;
    end
  end

  assign pat_ready = (state_q == StIdle);
  assign busy      = (state_q == StShift) || (state_q == StDone);
  assign done      = (state_q == StDone);
  assign C         = c_q;
  assign c_valid   = cv_q;

`ifdef SEQ_STIM_CHECK_EN
  typedef enum logic [1:0] {
    ChkS0,
    ChkS1,
    ChkS2,
    ChkS3
  } chk_e;

  chk_e       chk_q, chk_d;
  logic       y_exp;
  logic       err_q, err_d;
  logic [7:0] mcnt_q, mcnt_d;

  // Reference model of the downstream circuit; tracks C every cycle, not just while shifting.
  always_comb begin
    chk_d = chk_q;
    unique case (chk_q)
      ChkS0:   chk_d = c_q ? ChkS1 : ChkS0;
      ChkS1:   chk_d = c_q ? ChkS1 : ChkS3;
      ChkS2:   chk_d = c_q ? ChkS2 : ChkS0;
      ChkS3:   chk_d = c_q ? ChkS2 : ChkS3;
      default: chk_d = ChkS0;
    endcase
  end

  assign y_exp = (chk_q == ChkS3) || ((chk_q == ChkS2) && c_q);

  always_comb begin
    err_d  = err_q;
    mcnt_d = mcnt_q;
    if (accept) begin
      err_d  = 1'b0;
      mcnt_d = '0;
    end else if (cv_q && (Y != y_exp)) begin
      err_d = 1'b1;
      if (mcnt_q != 8'hff) begin
        mcnt_d = mcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q  <= ChkS0;
      err_q  <= 1'b0;
      mcnt_q <= '0;
    end else begin
      chk_q  <= chk_d;
      err_q  <= err_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign err          = err_q;
  assign mismatch_cnt = mcnt_q;
`else
  logic unused_y;
  assign unused_y = Y;
`endif

endmodule
